gfx_frame_regs: RTL and testbench
=================================

Name: gfx_frame_regs

Overview:
- Frame-synchronous register scheduler between the CPU-side bus (chipselect/databus/data_address) and the graphics object renderers.
- The CPU writes object positions, scores and game state into a shadow bank at any time. The block copies the shadow bank into the live bank only at the end-of-frame boundary, so the paddle, ball and score renderers never see a half-updated frame (no tearing).
- Its live outputs replace the constant position, score and state buffers in the graphics top level.

Parameters:
- CS_VALUE, 4'h2, chipselect value that qualifies a bus write to this block.
- LAST_ADDR, 19'h4AFFF, pixel_address of the final pixel of a frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- chipselect  in  4  bus select; a write occurs when it equals CS_VALUE.
- databus  in  16  write data.
- data_address  in  4  register index.
- VGA_ready  in  1  VGA controller consuming a pixel this cycle.
- pixel_address  in  19  current pixel address from Control.
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  16 each  live paddle positions.
- ball_x, ball_y, ball_z  out  16 each  live ball position.
- player_1_score, player_2_score  out  16 each  live scores.
- game_state  out  16  live game state.
- commit_pending  out  1  a commit is armed and waiting for frame end.
- frame_done  out  1  one-cycle pulse, the cycle after any live-bank update.
- frame_count  out  16  frames completed, wraps 16'hFFFF -> 0.

Behaviour:
- wr = (chipselect == CS_VALUE).
- frame_end = VGA_ready && (pixel_address == LAST_ADDR), combinational.
- Address map (wr only):
  - 0..9: shadow p1x, p1y, p2x, p2y, bx, by, bz, s1, s2, gs. Full 16-bit, no clamping.
  - A..D: ignored, no state change.
  - E: ctrl register; bit0 = auto_commit; other bits read-ignored, stored as 0. Takes effect the next cycle.
  - F: commit request; data ignored.
- Shadow writes land on the clock edge of the write cycle and are accepted in every state.
- Reset (rst == 0 at a clock edge) overrides everything, including mid-commit. It loads both banks identically:
  - p1x = 100, p1y = 200, p2x = 350, p2y = 250.
  - bx = 320, by = 240, bz = 0.
  - s1 = s2 = 0, gs = 0.
  - ctrl = 0, state IDLE, commit_pending = 0, frame_done = 0, frame_count = 0.
- FSM states:
  - IDLE: a write to F -> ARMED.
  - ARMED: on frame_end, at that clock edge copy all 10 shadow registers to live, then -> IDLE. Further writes to F while ARMED have no extra effect.
- Auto-commit: if auto_commit = 1, every frame_end copies shadow to live in any state. The FSM also returns to IDLE.
- Commit latency: live outputs change on the edge that samples frame_end, so they are visible the cycle after frame_end. frame_done is asserted in that same following cycle for exactly one cycle.
- Copy semantics: the copy uses shadow values as registered before the edge.
  - A shadow write in the same cycle as a commit is not included in that commit.
  - The written value stays in shadow and needs a new request (or auto-commit).
- Write to F in the same cycle as frame_end while IDLE: arms only. The commit happens at the next frame_end, not the current one.
- frame_count increments on every frame_end, independent of commits.
- commit_pending = (state == ARMED), registered.
- Live outputs are held between commits, regardless of bus activity.

Test Plan:
- Reset: hold rst = 0 for 2 cycles -> p1x = 100, p2y = 250, bx = 320, scores 0, commit_pending = 0, frame_count = 0.
- Write addr 0 = 16'd150 and addr 4 = 16'd400, no commit, run one frame end -> live p1x stays 100 and bx stays 320; frame_count = 1; no frame_done.
- Write addr 0 = 150, then addr F -> commit_pending = 1. At frame_end, p1x = 150 the next cycle, frame_done pulses once, commit_pending = 0.
- Write addr F and addr 7 = 16'd3 in the same cycle as frame_end while IDLE -> s1 unchanged that frame. Next frame_end: s1 = 3.
- ARMED with a write to addr 9 = 16'd2 coinciding with frame_end -> live gs takes the old shadow value, state IDLE. gs becomes 2 only after a further F write and frame_end.
- Write E = 1, then write addr 1 = 16'd222 with no F -> p1y = 222 after the next frame_end. Assert rst = 0 while ARMED mid-frame -> all values return to reset defaults and the commit is cancelled.

Source files
------------

// File: rtl/gfx_frame_regs_if.sv
// CPU-side register write bus into the frame register scheduler.
interface gfx_frame_regs_if;
  logic [3:0]  chipselect;
  logic [15:0] databus;
  logic [3:0]  data_address;

  modport master (output chipselect, databus, data_address);
  modport slave  (input  chipselect, databus, data_address);
endinterface

// File: rtl/gfx_frame_regs.sv
// Shadow/live register banks for the renderers; shadow is copied to live only at frame end.
// Latency: live outputs and frame_done update the cycle after frame_end. There is no backpressure; writes are always accepted.
module gfx_frame_regs #(
  parameter logic [3:0]  CS_VALUE  = 4'h2,
  parameter logic [18:0] LAST_ADDR = 19'h4AFFF
) (
  input  logic               clk,
  input  logic               rst,
  gfx_frame_regs_if.slave    bus,
  input  logic               VGA_ready,
  input  logic [18:0]        pixel_address,
  output logic [15:0]        paddle_1_x,
  output logic [15:0]        paddle_1_y,
  output logic [15:0]        paddle_2_x,
  output logic [15:0]        paddle_2_y,
  output logic [15:0]        ball_x,
  output logic [15:0]        ball_y,
  output logic [15:0]        ball_z,
  output logic [15:0]        player_1_score,
  output logic [15:0]        player_2_score,
  output logic [15:0]        game_state,
  output logic               commit_pending,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  typedef enum logic {IDLE, ARMED} state_t;

  // Index 0 is p1x ... index 9 is game state.
  localparam logic [9:0][15:0] RESET_BANK = {
    16'd0, 16'd0, 16'd0, 16'd0, 16'd240, 16'd320,
    16'd250, 16'd350, 16'd200, 16'd100
  };

  state_t            state_q, state_d;
  logic [9:0][15:0]  shadow_q, shadow_d;
  logic [9:0][15:0]  live_q;
  logic              auto_q, auto_d;
  logic              frame_done_q;
  logic [15:0]       frame_count_q;
  logic              wr, frame_end, commit;

  assign wr        = (bus.chipselect == CS_VALUE);
  assign frame_end = VGA_ready && (pixel_address == LAST_ADDR);

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    shadow_d = shadow_q;
    auto_d   = auto_q;

    if (wr && (bus.data_address <= 4'd9)) begin
      shadow_d[bus.data_address] = bus.databus;
    end
    if (wr && (bus.data_address == 4'hE)) begin
      auto_d = bus.databus[0];
    end

    case (state_q)
      IDLE: begin
        if (wr && (bus.data_address == 4'hF)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (frame_end) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (auto_q && frame_end) begin
      commit  = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      shadow_q      <= RESET_BANK;
      live_q        <= RESET_BANK;
      auto_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      auto_q       <= auto_d;
      frame_done_q <= commit;
      // The copy takes pre-edge shadow, so a same-cycle write waits for the next commit.
      if (commit) begin
        live_q <= shadow_q;
      end
      if (frame_end) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign paddle_1_x     = live_q[0];
  assign paddle_1_y     = live_q[1];
  assign paddle_2_x     = live_q[2];
  assign paddle_2_y     = live_q[3];
  assign ball_x         = live_q[4];
  assign ball_y         = live_q[5];
  assign ball_z         = live_q[6];
  assign player_1_score = live_q[7];
  assign player_2_score = live_q[8];
  assign game_state     = live_q[9];
  assign commit_pending = (state_q == ARMED);
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_gfx_frame_regs.sv
// Directed stimulus with a queued scoreboard; a negedge monitor compares DUT outputs and frame_done pulses.
module tb_gfx_frame_regs;
  localparam logic [3:0]  CS   = 4'h2;
  localparam logic [18:0] LAST = 19'h4AFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        VGA_ready = 1'b0;
  logic [18:0] pixel_address = 19'd0;
  logic [15:0] paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
  logic [15:0] ball_x, ball_y, ball_z, player_1_score, player_2_score, game_state;
  logic        commit_pending, frame_done;
  logic [15:0] frame_count;

  gfx_frame_regs_if bus ();

  gfx_frame_regs #(.CS_VALUE(CS), .LAST_ADDR(LAST)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .VGA_ready(VGA_ready), .pixel_address(pixel_address),
    .paddle_1_x(paddle_1_x), .paddle_1_y(paddle_1_y),
    .paddle_2_x(paddle_2_x), .paddle_2_y(paddle_2_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_z(ball_z),
    .player_1_score(player_1_score), .player_2_score(player_2_score),
    .game_state(game_state), .commit_pending(commit_pending),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam int P1X = 0, P1Y = 1, P2X = 2, P2Y = 3, BX = 4, S1 = 7, S2 = 8, GS = 9;
  localparam int CP = 10, FC = 12, FDQ = 13;

  function automatic logic [15:0] dut_val(input int sel);
    case (sel)
      0:  return paddle_1_x;
      1:  return paddle_1_y;
      2:  return paddle_2_x;
      3:  return paddle_2_y;
      4:  return ball_x;
      5:  return ball_y;
      6:  return ball_z;
      7:  return player_1_score;
      8:  return player_2_score;
      9:  return game_state;
      10: return {15'd0, commit_pending};
      12: return frame_count;
      13: return 16'(fd_q.size());
      default: return 16'hDEAD;
    endcase
  endfunction

  // Monitor: drains pending expectations and checks every frame_done pulse.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] fc_exp;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (dut_val(e.sel) !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", e.name, dut_val(e.sel), e.val);
      end
    end
    if (rst && frame_done !== 1'b0) begin
      n_tests++;
      if (fd_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_done_unexpected: got 1 expected 0 (frame_count=%0d)", frame_count);
      end else begin
        fc_exp = fd_q.pop_front();
        if (frame_count !== fc_exp) begin
          n_fail++;
          $display("FAIL frame_done_count: got %0d expected %0d", frame_count, fc_exp);
        end
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input logic [15:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] cs, input logic [3:0] a, input logic [15:0] d,
                     input logic vr, input logic [18:0] pa);
    @(negedge clk);
    bus.chipselect   = cs;
    bus.data_address = a;
    bus.databus      = d;
    VGA_ready        = vr;
    pixel_address    = pa;
    @(posedge clk);
    #1;
    bus.chipselect = 4'h0;
    VGA_ready      = 1'b0;
    pixel_address  = 19'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic fe);
    cyc(CS, a, d, fe, fe ? LAST : 19'd0);
  endtask

  task automatic idle(input logic fe);
    cyc(4'h0, 4'h0, 16'h0, fe, fe ? LAST : 19'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.chipselect = 4'h0; bus.data_address = 4'h0; bus.databus = 16'h0;

    // Reset held for two cycles
    idle(1'b0); idle(1'b0);
    rst = 1'b1;
    expect_v("rst_p1x", P1X, 16'd100); expect_v("rst_p2y", P2Y, 16'd250);
    expect_v("rst_bx", BX, 16'd320);   expect_v("rst_s1", S1, 16'd0);
    expect_v("rst_s2", S2, 16'd0);     expect_v("rst_cp", CP, 16'd0);
    expect_v("rst_fc", FC, 16'd0);

    // Shadow writes without a request leave live untouched
    wr(4'h0, 16'd150, 1'b0); wr(4'h4, 16'd400, 1'b0);
    wr(4'hA, 16'd999, 1'b0);
    idle(1'b1);
    expect_v("nocommit_p1x", P1X, 16'd100); expect_v("nocommit_bx", BX, 16'd320);
    expect_v("nocommit_fc", FC, 16'd1);

    // Near-miss frame ends must not count
    cyc(4'h0, 4'h0, 16'h0, 1'b1, LAST - 19'd1);
    cyc(4'h0, 4'h0, 16'h0, 1'b0, LAST);
    expect_v("nearmiss_fc", FC, 16'd1);

    // Requested commit
    wr(4'hF, 16'h0, 1'b0);
    expect_v("arm_cp", CP, 16'd1);
    wr(4'hF, 16'h1234, 1'b0);
    expect_v("rearm_cp", CP, 16'd1);
    idle(1'b1);
    fd_q.push_back(16'd2);
    expect_v("commit_p1x", P1X, 16'd150); expect_v("commit_bx", BX, 16'd400);
    expect_v("commit_cp", CP, 16'd0);
    idle(1'b0);

    // Arm on the frame_end cycle defers commit to the next frame
    wr(4'h7, 16'd3, 1'b0);
    wr(4'hF, 16'h0, 1'b1);
    expect_v("armfe_s1", S1, 16'd0); expect_v("armfe_cp", CP, 16'd1);
    expect_v("armfe_fc", FC, 16'd3);
    idle(1'b1);
    fd_q.push_back(16'd4);
    expect_v("next_s1", S1, 16'd3); expect_v("next_cp", CP, 16'd0);

    // Shadow write coinciding with commit is excluded from it
    wr(4'hF, 16'h0, 1'b0);
    wr(4'h9, 16'd2, 1'b1);
    fd_q.push_back(16'd5);
    expect_v("race_gs", GS, 16'd0); expect_v("race_cp", CP, 16'd0);
    wr(4'hF, 16'h0, 1'b0);
    idle(1'b1);
    fd_q.push_back(16'd6);
    expect_v("late_gs", GS, 16'd2);

    // Ctrl bits other than bit0 do not enable auto-commit
    wr(4'hE, 16'hFFFE, 1'b0);
    wr(4'h3, 16'd77, 1'b0);
    idle(1'b1);
    expect_v("noauto_p2y", P2Y, 16'd250); expect_v("noauto_fc", FC, 16'd7);

    // Auto-commit
    wr(4'hE, 16'h0001, 1'b0);
    wr(4'h1, 16'd222, 1'b0);
    idle(1'b1);
    fd_q.push_back(16'd8);
    expect_v("auto_p1y", P1Y, 16'd222); expect_v("auto_p2y", P2Y, 16'd77);
    expect_v("auto_cp", CP, 16'd0);

    // Reset while armed cancels everything
    wr(4'hF, 16'h0, 1'b0);
    expect_v("prerst_cp", CP, 16'd1);
    wr(4'h0, 16'd5, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_v("mrst_p1x", P1X, 16'd100); expect_v("mrst_p1y", P1Y, 16'd200);
    expect_v("mrst_p2y", P2Y, 16'd250); expect_v("mrst_s1", S1, 16'd0);
    expect_v("mrst_gs", GS, 16'd0);     expect_v("mrst_cp", CP, 16'd0);
    expect_v("mrst_fc", FC, 16'd0);
    idle(1'b1);
    expect_v("postrst_p1x", P1X, 16'd100); expect_v("postrst_fc", FC, 16'd1);
    expect_v("postrst_cp", CP, 16'd0);

    idle(1'b0); idle(1'b0);
    expect_v("frame_done_drained", FDQ, 16'd0);
    idle(1'b0); idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
